// File: rtl/b2g_shared_arbiter.sv
// rtl/b2g_shared_arbiter.sv - round-robin arbiter sharing one binary-to-Gray converter
// Picks one valid requester per cycle and registers its Gray-coded word with the winner's ID.

module binary_to_gray #(
  parameter int N = 16
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);
  assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

module b2g_shared_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [IDW-1:0]    out_id,
  output logic              busy
);

  logic            out_valid_q;
  logic [N-1:0]    out_data_q;
  logic [IDW-1:0]  out_id_q;
  logic [IDW-1:0]  last_grant_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_id;
  logic            found;
  logic [N-1:0]    sel_word;
  logic [N-1:0]    sel_gray;
  logic            accept;
  logic            xfer;

  // Two passes: requesters above the pointer first, then wrap to those at or below it.
  always_comb begin
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i > int'(last_grant_q)) && req_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        win_id   = i[IDW-1:0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i <= int'(last_grant_q)) && req_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        win_id   = i[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_word = req_data[i*N +: N];
    end
  end

  binary_to_gray #(.N(N)) u_b2g (
    .bin_i  (sel_word),
    .gray_o (sel_gray)
  );

  assign accept    = !out_valid_q || out_ready;
  assign req_ready = rst ? '0 : (grant & {NREQ{accept}});
  assign xfer      = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
    end else if (xfer) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= sel_gray;
      out_id_q     <= win_id;
      last_grant_q <= win_id;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = out_valid_q || (|req_valid);

endmodule

// File: tb/tb_b2g_shared_arbiter.sv
// tb/tb_b2g_shared_arbiter.sv - self-checking bench for b2g_shared_arbiter
// Directed scenarios with literal expectations, then randomized traffic against a queue-free model.

module tb_b2g_shared_arbiter;
  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      out_data;
  logic [IDW-1:0]    out_id;
  logic              busy;

  int checks = 0;
  int fails  = 0;

  bit          m_known = 1'b0;
  bit          m_valid;
  logic [N-1:0] m_data;
  int          m_id;
  int          m_last;
  logic [NREQ-1:0] rr_seen;

  b2g_shared_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] gray_of(input logic [N-1:0] b);
    logic [N-1:0] g;
    for (int k = 0; k < N; k++) g[k] = (k == N-1) ? b[k] : (b[k] ^ b[k+1]);
    return g;
  endfunction

  function automatic logic [N-1:0] word_of(input int i);
    return req_data[i*N +: N];
  endfunction

  // Called with inputs already driven just after a falling edge.
  task automatic cycle();
    int w;
    bit acc;
    logic [NREQ-1:0] exp_rr;
    #1;
    acc = !m_valid || out_ready;
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    exp_rr = '0;
    if (!rst && m_known && acc && w >= 0) exp_rr[w] = 1'b1;
    rr_seen = req_ready;
    if (rst || m_known) chk("req_ready", req_ready, exp_rr);
    if (m_known) begin
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_id", out_id, m_id);
      chk("busy", busy, m_valid || (req_valid != 0));
    end
    @(posedge clk);
    if (rst) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_last  = NREQ - 1;
    end else if (exp_rr != 0) begin
      m_valid = 1'b1;
      m_data  = gray_of(word_of(w));
      m_id    = w;
      m_last  = w;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int seq_id [5];
    logic [N-1:0] seq_d [5];
    seq_id = '{0, 1, 2, 3, 0};
    seq_d  = '{16'h000E, 16'h8000, 16'hC000, 16'h0001, 16'h000E};

    // Reset with every requester asserting
    rst = 1'b1; req_valid = '1; out_ready = 1'b1;
    req_data = {16'h0001, 16'h8000, 16'hFFFF, 16'h000B};
    cycle(); cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_id", out_id, 2'd0);
    rst = 1'b1; cycle();
    chk("rst_req_ready", rr_seen, 4'b0000);
    rst = 1'b0;

    // Round-robin across all four
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_id", out_id, seq_id[k]);
      chk("rr_data", out_data, seq_d[k]);
      chk("rr_valid", out_valid, 1'b1);
    end

    // Single requester
    req_valid = 4'b0100; req_data[2*N +: N] = 16'h1234;
    cycle();
    chk("single_ready", rr_seen, 4'b0100);
    chk("single_valid", out_valid, 1'b1);
    chk("single_id", out_id, 2'd2);
    chk("single_data", out_data, 16'h1B2E);

    // Pointer hold and wrap
    req_valid = 4'b0010; cycle(); chk("ptr_id1", out_id, 2'd1);
    req_valid = 4'b1000; cycle(); chk("ptr_id3", out_id, 2'd3);
    req_valid = 4'b0101; cycle(); chk("ptr_wrap0", out_id, 2'd0);

    // Backpressure then drain+fill without a bubble
    req_valid = '1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", rr_seen, 4'b0000);
      chk("bp_id", out_id, 2'd0);
      chk("bp_data", out_data, 16'h000E);
      chk("bp_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1; cycle();
    chk("fill_ready", rr_seen, 4'b0010);
    chk("fill_valid", out_valid, 1'b1);
    chk("fill_id", out_id, 2'd1);
    chk("fill_data", out_data, 16'h8000);

    // Reset while a result is stalled
    out_ready = 1'b0; rst = 1'b1; cycle();
    chk("mid_rst_valid", out_valid, 1'b0);
    rst = 1'b0; out_ready = 1'b1; cycle();
    chk("post_rst_id", out_id, 2'd0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if ($urandom_range(0, 3) == 0) req_valid = '1;
      for (int i = 0; i < NREQ; i++) req_data[i*N +: N] = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; req_valid = '0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
